// File: rtl/pim_pkg.sv
// pim_pkg: shared opcode, error-cause and controller-state types for the PIM issue path.
package pim_pkg;

    typedef enum logic [2:0] {
        PIM_LOAD  = 3'b000,
        PIM_STORE = 3'b001,
        PIM_MAC   = 3'b010
    } pim_op_e;

    typedef enum logic [1:0] {
        CAUSE_BUS      = 2'b00,
        CAUSE_ILLEGAL  = 2'b01,
        CAUSE_MISALIGN = 2'b10,
        CAUSE_TIMEOUT  = 2'b11
    } pim_err_cause_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_RSP,
        S_WB
    } ctrl_state_e;

    localparam logic [2:0] F3_LOAD  = 3'b000;
    localparam logic [2:0] F3_STORE = 3'b001;
    localparam logic [2:0] F3_MAC   = 3'b010;

    function automatic logic op_legal(input logic [2:0] f3);
        return (f3 == F3_LOAD) || (f3 == F3_STORE) || (f3 == F3_MAC);
    endfunction

endpackage

// File: rtl/pim_watchdog.sv
// pim_watchdog: response watchdog; clear_i restarts the count, start_i counts one silent cycle,
// expired_o flags the cycle on which the count reaches LIMIT.
module pim_watchdog #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic start_i,
    output logic expired_o
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign expired_o = start_i && (cnt_q == W'(LIMIT - 1));
    assign cnt_d     = clear_i ? '0 : start_i ? cnt_q + W'(1) : cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/pim_issue_ctrl.sv
// pim_issue_ctrl: issues PIM load/store/MAC instructions onto the PIM port and writes results back.
// Optional response watchdog enabled by defining PIM_TIMEOUT_EN.
module pim_issue_ctrl
    import pim_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        issue_valid_i,
    output logic        issue_ready_o,
    input  logic [2:0]  issue_funct3_i,
    input  logic [4:0]  issue_rd_i,
    input  logic [31:0] issue_rs1_data_i,
    input  logic [31:0] issue_rs2_data_i,
    input  logic [31:0] issue_imm_i,
    input  logic        flush_i,
    output logic        pim_req_o,
    input  logic        pim_gnt_i,
    output logic [2:0]  pim_op_o,
    output logic [31:0] pim_addr_o,
    output logic [31:0] pim_wdata_o,
    input  logic        pim_rvalid_i,
    input  logic [31:0] pim_rdata_i,
    input  logic        pim_err_i,
    output logic        stall_o,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        err_o,
    output logic [1:0]  err_cause_o
);

    ctrl_state_e    state_q;
    logic           req_q, wb_valid_q, err_q;
    logic [2:0]     op_q;
    logic [4:0]     rd_q;
    logic [31:0]    addr_q, wdata_q, wb_data_q;
    pim_err_cause_e cause_q;
    logic [31:0]    addr_d;
    logic           wd_expired;

    assign addr_d        = issue_rs1_data_i + issue_imm_i;
    assign issue_ready_o = (state_q == S_IDLE);
    assign stall_o       = (state_q != S_IDLE);

`ifdef PIM_TIMEOUT_EN
    pim_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (state_q == S_REQ && pim_gnt_i),
        .start_i   (state_q == S_WAIT_RSP && !pim_rvalid_i),
        .expired_o (wd_expired)
    );
`else
    logic unused_cfg;
    assign unused_cfg = ^TIMEOUT_CYCLES;
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            req_q      <= 1'b0;
            wb_valid_q <= 1'b0;
            err_q      <= 1'b0;
            op_q       <= '0;
            rd_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wb_data_q  <= '0;
            cause_q    <= CAUSE_BUS;
        end else begin
            wb_valid_q <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                S_IDLE: if (issue_valid_i) begin
                    op_q    <= issue_funct3_i;
                    rd_q    <= issue_rd_i;
                    wdata_q <= issue_rs2_data_i;
                    addr_q  <= addr_d;
                    if (!op_legal(issue_funct3_i)) begin
                        err_q   <= 1'b1;
                        cause_q <= CAUSE_ILLEGAL;
                    end else if (addr_d[1:0] != 2'b00) begin
                        err_q   <= 1'b1;
                        cause_q <= CAUSE_MISALIGN;
                    end else begin
                        state_q <= S_REQ;
                        req_q   <= 1'b1;
                    end
                end
                // grant takes priority over a same-cycle flush
                S_REQ: if (pim_gnt_i || flush_i) begin
                    state_q <= pim_gnt_i ? S_WAIT_RSP : S_IDLE;
                    req_q   <= 1'b0;
                end
                S_WAIT_RSP: if (pim_rvalid_i) begin
                    if (pim_err_i) begin
                        err_q   <= 1'b1;
                        cause_q <= CAUSE_BUS;
                        state_q <= S_IDLE;
                    end else if (op_q == F3_STORE) begin
                        state_q <= S_IDLE;
                    end else begin
                        wb_data_q  <= pim_rdata_i;
                        wb_valid_q <= (rd_q != 5'd0);
                        state_q    <= S_WB;
                    end
                end else if (wd_expired) begin
                    err_q   <= 1'b1;
                    cause_q <= CAUSE_TIMEOUT;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign pim_req_o   = req_q;
    assign pim_op_o    = op_q;
    assign pim_addr_o  = addr_q;
    assign pim_wdata_o = wdata_q;
    assign wb_valid_o  = wb_valid_q;
    assign wb_rd_o     = rd_q;
    assign wb_data_o   = wb_data_q;
    assign err_o       = err_q;
    assign err_cause_o = cause_q;

endmodule
